// File: rtl/countdown_ctrl_pkg.sv
// Shared definitions for the BCD countdown controller.
//   state_e   : FSM state encoding as seen on the State output
//               (IDLE=0, RUN=1, PAUSE=2, DONE=3).
//   BCD_MAX   : largest legal value of a single decimal digit.
//   clamp_bcd : limits a 4-bit value to a legal BCD digit.
package countdown_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Nibbles A..F are not decimal digits; they are loaded as 9.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// Single down-counting decimal digit.
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, digit -> 0
//   load     : capture load_val (clamped to 9) into the digit
//   load_val : value to load
//   dec      : decrement by one this cycle; 0 rolls to 9
//   digit    : current digit value, always 0..9
//   borrow   : dec while digit is 0, i.e. the next digit up must decrement
module bcd_digit_dn
  import countdown_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow
);

  logic [3:0] digit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else if (load) begin
      digit_q <= clamp_bcd(load_val);
    end else if (dec) begin
      digit_q <= (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec && (digit_q == 4'd0);

endmodule

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown controller with start/pause/load control.
//   RELOAD : 1 = after terminal count, reload Preset and run again
//   CLK    : clock, rising edge
//   Reset  : asynchronous active-high reset
//   Load   : capture Preset (digits clamped to 9)
//   Preset : start value, [7:4] tens, [3:0] ones
//   Start  : begin or resume counting
//   Pause  : suspend counting
//   Tick   : count-enable qualifier, one decrement per qualified cycle
//   Q      : current count, BCD
//   State  : IDLE=0, RUN=1, PAUSE=2, DONE=3
//   Busy   : State is RUN or PAUSE
//   Done   : one-cycle pulse in the first cycle of DONE after a terminal count
// Input priority within a cycle is Load > Pause > Start > Tick, applied only
// to the inputs that the current state responds to.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter bit RELOAD = 1'b0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] Preset,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Tick,
  output logic [7:0] Q,
  output logic [1:0] State,
  output logic       Busy,
  output logic       Done
);

  state_e     state_q;
  logic       done_q;

  logic       digit_load;
  logic       ones_dec;
  logic       ones_borrow;
  logic       unused_tens_borrow;
  logic [3:0] ones;
  logic [3:0] tens;

  logic       q_is_zero;
  logic       q_is_one;
  logic       preset_zero;

  assign q_is_zero   = (tens == 4'd0) && (ones == 4'd0);
  assign q_is_one    = (tens == 4'd0) && (ones == 4'd1);
  assign preset_zero = (clamp_bcd(Preset[7:4]) == 4'd0) && (clamp_bcd(Preset[3:0]) == 4'd0);

  // Digit control. Loads and decrements are mutually exclusive by state.
  always_comb begin
    digit_load = 1'b0;
    ones_dec   = 1'b0;
    unique case (state_q)
      StIdle:  digit_load = Load;
      StRun:   ones_dec   = Tick && !Pause;
      StPause: digit_load = Load;
      StDone: begin
        // done_q marks the first DONE cycle: the only cycle an auto-reload
        // may happen. A reload of 00 leaves us parked in DONE.
        digit_load = Load || (RELOAD && done_q);
      end
      default: ;
    endcase
  end

  bcd_digit_dn u_ones (
    .clk      (CLK),
    .rst      (Reset),
    .load     (digit_load),
    .load_val (Preset[3:0]),
    .dec      (ones_dec),
    .digit    (ones),
    .borrow   (ones_borrow)
  );

  // Tens borrow would mean a wrap below 00, which the FSM never allows.
  bcd_digit_dn u_tens (
    .clk      (CLK),
    .rst      (Reset),
    .load     (digit_load),
    .load_val (Preset[7:4]),
    .dec      (ones_borrow),
    .digit    (tens),
    .borrow   (unused_tens_borrow)
  );

  // Control FSM with registered Done pulse.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Load || Pause) begin
            state_q <= StIdle;
          end else if (Start) begin
            if (q_is_zero) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (Pause) begin
            state_q <= StPause;
          end else if (Tick && q_is_one) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StPause: begin
          if (Load) begin
            state_q <= StIdle;
          end else if (!Pause && Start) begin
            state_q <= StRun;
          end
        end
        StDone: begin
          if (Load) begin
            state_q <= StIdle;
          end else if (RELOAD && done_q && !preset_zero) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Q     = {tens, ones};
  assign State = state_q;
  assign Busy  = (state_q == StRun) || (state_q == StPause);
  assign Done  = done_q;

endmodule

// File: doc/countdown_ctrl.md
COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter RELOAD, default 0, meaning 1 = automatic reload from Preset and restart after terminal count.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Load  input  1  capture Preset into the counter.
REQ-005 Preset  input  8  start value; [7:4] tens BCD digit, [3:0] ones BCD digit.
REQ-006 Start  input  1  begin or resume counting.
REQ-007 Pause  input  1  suspend counting.
REQ-008 Tick  input  1  count-enable qualifier; one decrement per qualified cycle.
REQ-009 Q  output  8  current count; [7:4] tens, [3:0] ones, always valid BCD.
REQ-010 State  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-011 Busy  output  1  high when State is RUN or PAUSE.
REQ-012 Done  output  1  single-cycle pulse on terminal count.

Function
REQ-013 Per-cycle input priority SHALL be Load > Pause > Start > Tick.
REQ-014 Preset digits above 9 SHALL be clamped to 9 when loaded.
REQ-015 IDLE: Load -> Q<=Preset, stay IDLE; Start with Q!=00 -> RUN; Start with Q==00 -> DONE.
REQ-016 RUN: Tick decrements Q by one decimal unit; ones 0->9 with tens borrow; no decrement without Tick.
REQ-017 RUN: Tick with Q==01 -> Q<=00 and State<=DONE in the same edge.
REQ-018 RUN: Pause -> PAUSE with no decrement that cycle, even if Tick is high.
REQ-019 RUN: Load and Start are ignored.
REQ-020 PAUSE: Q holds, Tick ignored; Start -> RUN; Load -> Q<=Preset, State<=IDLE.
REQ-021 DONE: Done SHALL be high exactly in the first cycle State==DONE, low otherwise.
REQ-022 DONE, RELOAD=0: Q holds 00; Load -> Q<=Preset, IDLE; Start, Pause, Tick ignored.
REQ-023 DONE, RELOAD=1: one cycle after entry, Q<=Preset (clamped), State<=RUN if loaded value !=00, else remain DONE with no further Done pulse; Load in that cycle takes priority -> IDLE.
REQ-024 Q SHALL never wrap below 00; a decrement at 00 is impossible by construction.
REQ-025 Busy SHALL be decoded from the state register with no added latency.

Reset
REQ-026 Reset high SHALL immediately force Q=00, State=IDLE, Busy=0, Done=0, independent of CLK.
REQ-027 Reset asserted mid-count SHALL abandon the count with no Done pulse.
REQ-028 First edge after Reset release SHALL obey IDLE rules.

Structure
REQ-029 Shared package countdown_ctrl_pkg SHALL hold the state encodings (IDLE, RUN, PAUSE, DONE) and constant BCD_MAX=9.
REQ-030 One sub-module bcd_digit_dn SHALL implement a single down-counting decimal digit: load, clamp, decrement enable, borrow-out when digit==0 and decrement enabled; instantiated twice with ones borrow-out driving tens decrement.
REQ-031 FSM and Done generation SHALL reside in countdown_ctrl; no combinational path from inputs to Q.

Verification
REQ-032 Reset, Load Preset=8'h12, Start, Tick every cycle -> Q 12,11,10,09,...,01,00; Done pulse once with State=3; 12 ticks total.
REQ-033 Preset=8'h20, RUN, Tick and Pause same cycle at Q=8'h15 -> Q stays 15, State=2; Start -> resumes at 14 on next Tick.
REQ-034 Load Preset=8'hAF -> Q=8'h99; Start with Preset 8'h00 loaded -> State DONE directly, one Done pulse.
REQ-035 RELOAD=1, Preset=8'h03, Tick continuous -> Q 03,02,01,00,03,02,...; Done pulse every 4th count.
REQ-036 Reset asserted between clock edges at Q=8'h07 in RUN -> Q=00, State=0 immediately; no Done.
REQ-037 Tick gated 1-in-3, Preset=8'h10 -> Q 10->09 borrow on first qualified Tick; Busy high throughout RUN, low in DONE.
